// File: rtl/zeroheti_pkg.sv
// Shared types and constants for the zeroheti APB interconnect.
//   apb_rule_t      : one address window, [base, last) with last exclusive
//   err_type_e      : fault classification reported by the peripheral hub
//   hub_state_e     : transfer state of the hub
//   AddrMap         : peripheral windows of the default system map
//   DefaultApbRules : four-entry rule table built from AddrMap
package zeroheti_pkg;

  localparam int RuleAddrWidth = 32;

  typedef struct packed {
    logic [RuleAddrWidth-1:0] base;
    logic [RuleAddrWidth-1:0] last;
  } apb_rule_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    UNMAPPED = 2'd1,
    SLVERR   = 2'd2,
    TIMEOUT  = 2'd3
  } err_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } hub_state_e;

  typedef struct packed {
    apb_rule_t uart;
    apb_rule_t mtimer;
    apb_rule_t i2c;
  } addr_map_t;

  localparam addr_map_t AddrMap = '{
    uart:   '{base: 32'h0003_0000, last: 32'h0003_1000},
    mtimer: '{base: 32'h0003_1000, last: 32'h0003_2000},
    i2c:    '{base: 32'h0003_2000, last: 32'h0003_3000}
  };

  // The spare fourth port gets an empty window (base == last) so it never matches.
  localparam apb_rule_t SpareRule = '{base: 32'h0, last: 32'h0};

  localparam apb_rule_t [3:0] DefaultApbRules = {SpareRule, AddrMap.i2c, AddrMap.mtimer, AddrMap.uart};

  // Width of a port index; a single-port hub still needs one bit.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic rule_match(apb_rule_t rule, logic [RuleAddrWidth-1:0] addr);
    return (addr >= rule.base) && (addr < rule.last);
  endfunction

endpackage

// File: rtl/apb_rule_decode.sv
// Combinational address decoder against an APB rule table.
//   paddr : address to decode
//   hit   : some rule matches
//   idx   : index of the lowest-numbered matching rule (0 when no hit)
module apb_rule_decode import zeroheti_pkg::*; #(
  parameter int NumPerip = 4,
  parameter int AddrWidth = 32,
  parameter apb_rule_t [NumPerip-1:0] Rules = DefaultApbRules,
  localparam int IdxWidth = idx_width(NumPerip)
) (
  input  logic [AddrWidth-1:0] paddr,
  output logic                 hit,
  output logic [IdxWidth-1:0]  idx
);

  logic [RuleAddrWidth-1:0] addr_ext;

  assign addr_ext = RuleAddrWidth'(paddr);

  // Scanning from the top down lets the lowest matching index overwrite the rest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NumPerip - 1; i >= 0; i--) begin
      if (rule_match(Rules[i], addr_ext)) begin
        hit = 1'b1;
        idx = IdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/apb_periph_hub.sv
// APB fan-out hub: one manager port to NumPerip subordinates.
//   clk_i, rst_ni            : clock, async active-low reset
//   m_*                      : manager-side APB port
//   s_psel_o                 : one-hot subordinate select
//   s_penable_o/pwrite/paddr/pwdata : broadcast to all subordinates
//   s_prdata_i/pready_i/pslverr_i   : per-subordinate responses
//   err_clr_i                : clears fault status
//   err_count_o              : saturating fault count
//   last_err_addr_o/type_o   : address and kind of the latest fault
//   bus_err_irq_o            : one-cycle pulse per fault
// Unmapped accesses get an error response from the hub; stalled accesses are
// aborted with ErrData after TimeoutCycles access cycles.
module apb_periph_hub import zeroheti_pkg::*; #(
  parameter int NumPerip = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int TimeoutCycles = 16,
  parameter logic [DataWidth-1:0] ErrData = 32'hDEAD_BEEF,
  parameter apb_rule_t [NumPerip-1:0] AddrRules = DefaultApbRules,
  localparam int IdxWidth = idx_width(NumPerip)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               m_psel_i,
  input  logic                               m_penable_i,
  input  logic                               m_pwrite_i,
  input  logic [AddrWidth-1:0]               m_paddr_i,
  input  logic [DataWidth-1:0]               m_pwdata_i,
  output logic [DataWidth-1:0]               m_prdata_o,
  output logic                               m_pready_o,
  output logic                               m_pslverr_o,
  output logic [NumPerip-1:0]                s_psel_o,
  output logic                               s_penable_o,
  output logic                               s_pwrite_o,
  output logic [AddrWidth-1:0]               s_paddr_o,
  output logic [DataWidth-1:0]               s_pwdata_o,
  input  logic [NumPerip-1:0][DataWidth-1:0] s_prdata_i,
  input  logic [NumPerip-1:0]                s_pready_i,
  input  logic [NumPerip-1:0]                s_pslverr_i,
  input  logic                               err_clr_i,
  output logic [7:0]                         err_count_o,
  output logic [AddrWidth-1:0]               last_err_addr_o,
  output logic [1:0]                         last_err_type_o,
  output logic                               bus_err_irq_o
);

  hub_state_e state, state_next;

  logic                 live_hit;
  logic [IdxWidth-1:0]  live_idx;
  logic                 hit_q;
  logic [IdxWidth-1:0]  idx_q;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           wait_cnt;
  logic                 setup;
  logic                 load;
  logic                 cnt_inc;
  logic                 fault;
  err_type_e            fault_type;
  err_type_e            err_type;

  apb_rule_decode #(
    .NumPerip (NumPerip),
    .AddrWidth(AddrWidth),
    .Rules    (AddrRules)
  ) u_decode (
    .paddr(m_paddr_i),
    .hit  (live_hit),
    .idx  (live_idx)
  );

  assign setup      = m_psel_i & ~m_penable_i;
  assign s_pwrite_o = m_pwrite_i;
  assign s_paddr_o  = m_paddr_i;
  assign s_pwdata_o = m_pwdata_i;

  // Transfer FSM: routes select/response and flags faults for the status block.
  always_comb begin
    state_next  = state;
    s_psel_o    = '0;
    s_penable_o = 1'b0;
    m_prdata_o  = '0;
    m_pready_o  = 1'b0;
    m_pslverr_o = 1'b0;
    load        = 1'b0;
    cnt_inc     = 1'b0;
    fault       = 1'b0;
    fault_type  = NONE;
    case (state)
      IDLE: begin
        if (setup) begin
          load       = 1'b1;
          state_next = ACCESS;
          if (live_hit) s_psel_o[live_idx] = 1'b1;
        end
      end
      ACCESS: begin
        if (!m_psel_i) begin
          // Manager abandoned the transfer: no response, nothing recorded.
          state_next = IDLE;
        end else if (hit_q) begin
          s_psel_o[idx_q] = 1'b1;
          s_penable_o     = m_penable_i;
          m_prdata_o      = s_prdata_i[idx_q];
          m_pready_o      = s_pready_i[idx_q];
          m_pslverr_o     = s_pslverr_i[idx_q];
          // A late pready in the final cycle still beats the abort.
          if (s_pready_i[idx_q]) begin
            state_next = IDLE;
            if (s_pslverr_i[idx_q]) begin
              fault      = 1'b1;
              fault_type = SLVERR;
            end
          end else if (wait_cnt == 8'(TimeoutCycles - 1)) begin
            s_psel_o    = '0;
            s_penable_o = 1'b0;
            m_prdata_o  = ErrData;
            m_pready_o  = 1'b1;
            m_pslverr_o = 1'b1;
            fault       = 1'b1;
            fault_type  = TIMEOUT;
            state_next  = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end else begin
          m_pready_o  = 1'b1;
          m_pslverr_o = 1'b1;
          fault       = 1'b1;
          fault_type  = UNMAPPED;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Setup-phase capture of the decode result and the access-cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q    <= 1'b0;
      idx_q    <= '0;
      addr_q   <= '0;
      wait_cnt <= '0;
    end else if (load) begin
      hit_q    <= live_hit;
      idx_q    <= live_idx;
      addr_q   <= m_paddr_i;
      wait_cnt <= '0;
    end else if (cnt_inc) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Fault status: a fault in the same cycle as a clear restarts the count at 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_o     <= '0;
      last_err_addr_o <= '0;
      err_type        <= NONE;
      bus_err_irq_o   <= 1'b0;
    end else begin
      bus_err_irq_o <= fault;
      if (fault) begin
        if (err_clr_i)                err_count_o <= 8'd1;
        else if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
        last_err_addr_o <= addr_q;
        err_type        <= fault_type;
      end else if (err_clr_i) begin
        err_count_o     <= '0;
        last_err_addr_o <= '0;
        err_type        <= NONE;
      end
    end
  end

  assign last_err_type_o = err_type;

endmodule
